// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU job arbiter: FSM state encoding, the
// activation/weight lane width, and the helper that locates a requester's
// slice inside a flattened per-requester bus.
package tpu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    RUN     = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  // Bits per activation/weight element.
  localparam int ACT_W = 8;

  // Lowest bit of requester idx's N-element vector in a flattened bus.
  function automatic int slice_lo(input int idx, input int n);
    return idx * n * ACT_W;
  endfunction

endpackage

// File: rtl/tpu_job_arbiter_rr_pick.sv
// rr_pick: combinational rotating priority encoder. The search starts at
// ptr_i and wraps modulo R. The first set request bit wins and is returned
// both one-hot and as an index.
module rr_pick #(
  parameter int R     = 4,
  parameter int IDX_W = 2
) (
  input  logic [R-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [R-1:0]     win_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  localparam int PW = IDX_W + 1;

  logic [PW-1:0] pos;

  // Walk R positions from the pointer and keep the first requester found.
  always_comb begin
    win_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    pos     = '0;
    for (int k = 0; k < R; k++) begin
      pos = {1'b0, ptr_i} + PW'(k);
      if (pos >= PW'(R)) pos = pos - PW'(R);
      if (!valid_o && req_i[pos[IDX_W-1:0]]) begin
        valid_o                = 1'b1;
        idx_o                  = pos[IDX_W-1:0];
        win_o[pos[IDX_W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tpu_job_arbiter.sv
// tpu_job_arbiter: shares one tpu_top between R requesters. Each grant
// covers exactly one job: IDLE -> START (tpu_start pulse) -> RUN (wait for
// tpu_done) -> RELEASE (job_done pulse). Ownership rotates round-robin.
// While a requester owns the TPU, its act/weight slices are muxed onto the
// array inputs, and tpu_output_valid is routed back to it.
// Optional build macro TPU_ARB_WATCHDOG_EN adds a RUN-state watchdog.
// When the watchdog fires, it aborts the job with a job_err/tpu_srst pulse.
module tpu_job_arbiter
  import tpu_pkg::*;
#(
  parameter int N       = 8,
  parameter int R       = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [R-1:0]           req,
  input  logic [R*N*ACT_W-1:0]   act_in,
  input  logic [R*N*ACT_W-1:0]   weight_in,
  output logic [R-1:0]           grant,
  output logic [R-1:0]           job_done,
  output logic [R-1:0]           res_valid,
  output logic                   busy,
  output logic                   tpu_start,
  input  logic                   tpu_done,
  input  logic                   tpu_output_valid,
  output logic [N*ACT_W-1:0]     act_data,
  output logic [N*ACT_W-1:0]     weight_data,
  output logic [R-1:0]           job_err,
  output logic                   tpu_srst
);

  localparam int IDX_W = $clog2(R);
  localparam int VW    = N * ACT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(R - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [R-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] ptr_after_owner;

  logic [R-1:0]     win;
  logic [IDX_W-1:0] win_idx;
  logic             win_vld;
  logic             expire;

  rr_pick #(
    .R     (R),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .win_o   (win),
    .idx_o   (win_idx),
    .valid_o (win_vld)
  );

  // The rotation restarts just past the requester that held the TPU last.
  assign ptr_after_owner = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

`ifdef TPU_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT) + 1;

  logic [WD_W-1:0] wd_q, wd_d;
  logic [R-1:0]    err_q, err_d;
  logic            srst_q, srst_d;

  // Expiry is only a candidate. If tpu_done arrives in the same cycle,
  // the job completes normally.
  assign expire = (state_q == RUN) && (wd_q == WD_W'(TIMEOUT - 1));

  // Watchdog next-state: clear on START, count every RUN cycle, and arm
  // the abort pulses.
  always_comb begin
    wd_d = wd_q;
    if (state_q == START)    wd_d = '0;
    else if (state_q == RUN) wd_d = wd_q + 1'b1;
    err_d  = (expire && !tpu_done) ? grant_q : '0;
    srst_d = expire && !tpu_done;
  end

  // Watchdog counter and one-cycle abort pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q   <= '0;
      err_q  <= '0;
      srst_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      err_q  <= err_d;
      srst_q <= srst_d;
    end
  end

  assign job_err  = err_q;
  assign tpu_srst = srst_q;
`else
  assign expire   = 1'b0;
  assign job_err  = '0;
  assign tpu_srst = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic, including the ownership/rotation registers' next values.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          owner_d = win_idx;
          grant_d = win;
          state_d = START;
        end
      end
      START: state_d = RUN;
      RUN: begin
        if (tpu_done) begin
          state_d = RELEASE;
        end else if (expire) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = ptr_after_owner;
        end
      end
      RELEASE: begin
        state_d  = IDLE;
        grant_d  = '0;
        rr_ptr_d = ptr_after_owner;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ownership, grant and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= '0;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Outputs decoded from the state and owner. The data mux follows the
  // owner combinationally, so it adds no latency.
  always_comb begin
    tpu_start   = (state_q == START);
    busy        = (state_q != IDLE);
    job_done    = (state_q == RELEASE) ? grant_q : '0;
    res_valid   = tpu_output_valid ? grant_q : '0;
    act_data    = '0;
    weight_data = '0;
    if (|grant_q) begin
      act_data    = act_in[slice_lo(int'(owner_q), N) +: VW];
      weight_data = weight_in[slice_lo(int'(owner_q), N) +: VW];
    end
  end

  assign grant = grant_q;

endmodule

// File: tb/tb_tpu_job_arbiter.sv
// Randomized scoreboard bench for tpu_job_arbiter. The driver process emulates
// the requesters and the TPU. For every stimulus it pushes the expected
// responses, each with its due cycle, into a queue. A separate monitor
// process pops that queue whenever the DUT presents an event. It also checks
// the grant and data mux every cycle against the current expected owner.
`timescale 1ns/1ps
module tb_tpu_job_arbiter;

  localparam int N       = 8;
  localparam int R       = 4;
  localparam int TIMEOUT = 16;
  localparam int VW      = N * 8;

  localparam int K_START = 0;
  localparam int K_DONE  = 1;
  localparam int K_ERR   = 2;
  localparam int K_RES   = 3;

  typedef struct {
    int           kind;
    logic [R-1:0] val;
    int           cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [R-1:0]    req;
  logic [R*VW-1:0] act_in, weight_in;
  logic [R-1:0]    grant, job_done, res_valid, job_err;
  logic            busy, tpu_start, tpu_done, tpu_output_valid, tpu_srst;
  logic [VW-1:0]   act_data, weight_data;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc   = 0;
  exp_t         expq[$];
  int           mptr;
  logic [R-1:0] reqv;
  int           cur_own = -1;
  bit           m_rel;
  logic [R-1:0] m_exp_g;
  logic [VW-1:0] m_exp_a, m_exp_w;

  tpu_job_arbiter #(.N(N), .R(R), .TIMEOUT(TIMEOUT)) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .act_in           (act_in),
    .weight_in        (weight_in),
    .grant            (grant),
    .job_done         (job_done),
    .res_valid        (res_valid),
    .busy             (busy),
    .tpu_start        (tpu_start),
    .tpu_done         (tpu_done),
    .tpu_output_valid (tpu_output_valid),
    .act_data         (act_data),
    .weight_data      (weight_data),
    .job_err          (job_err),
    .tpu_srst         (tpu_srst)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "bench did not finish");
  end

  // ---------------- reference helpers ----------------
  function automatic logic [R-1:0] oh(input int i);
    logic [R-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int idx_of(input logic [R-1:0] v);
    for (int i = 0; i < R; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Round-robin rule: scan from the pointer, wrapping; the first requester wins.
  function automatic int pick(input logic [R-1:0] r, input int p);
    for (int k = 0; k < R; k++) if (r[(p + k) % R]) return (p + k) % R;
    return -1;
  endfunction

  function automatic logic [R*VW-1:0] rand_vec();
    logic [R*VW-1:0] v;
    for (int i = 0; i < R*VW/32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic chk(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, got, exp);
    end
  endtask

  task automatic push_exp(input int kind, input logic [R-1:0] val, input int c);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    expq.push_back(e);
  endtask

  // ---------------- monitor ----------------
  task automatic take(input int kind, input logic [R-1:0] val);
    exp_t e;
    n_cmp++;
    if (expq.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event at cycle %0d: kind=%0d val=%b, nothing expected", cyc, kind, val);
      return;
    end
    e = expq.pop_front();
    if (e.kind != kind || e.val !== val || e.cyc != cyc) begin
      n_bad++;
      $display("FAIL event at cycle %0d: got kind=%0d val=%b, expected kind=%0d val=%b at cycle %0d",
               cyc, kind, val, e.kind, e.val, e.cyc);
    end
    if (e.kind == K_START) cur_own = idx_of(e.val);
    if (e.kind == K_ERR)   cur_own = -1;
    if (e.kind == K_DONE)  m_rel = 1'b1;
  endtask

  always @(negedge clk) begin
    m_rel = 1'b0;
    if (tpu_start === 1'b1) take(K_START, grant);
    if (job_done !== '0) take(K_DONE, job_done);
    if (job_err !== '0 || tpu_srst !== 1'b0) begin
      take(K_ERR, job_err);
      chk("srst_with_err", {63'd0, tpu_srst}, 64'd1);
    end
    if (res_valid !== '0) take(K_RES, res_valid);
    m_exp_g = (cur_own >= 0) ? oh(cur_own) : '0;
    m_exp_a = (cur_own >= 0) ? act_in[cur_own*VW +: VW] : '0;
    m_exp_w = (cur_own >= 0) ? weight_in[cur_own*VW +: VW] : '0;
    chk("grant", grant, m_exp_g);
    chk("act_data", act_data, m_exp_a);
    chk("weight_data", weight_data, m_exp_w);
    if (m_rel || rst === 1'b1) cur_own = -1;
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
    if ($urandom_range(0, 3) == 0) begin
      act_in    = rand_vec();
      weight_in = rand_vec();
    end
  endtask

  // Called in an IDLE cycle with reqv != 0; returns in the first RUN cycle.
  task automatic arbitrate(output int w);
    req = reqv;
    w = pick(reqv, mptr);
    push_exp(K_START, oh(w), cyc + 1);
    step();
    tpu_done = 1'($urandom_range(0, 1));
    step();
    tpu_done = 1'b0;
  endtask

  // RUN for dly cycles, then tpu_done; returns in the next IDLE cycle.
  task automatic run_body(input int w, input int dly, input bit keep,
                          input logic [R-1:0] arrive, input bit rnd);
    reqv = reqv | arrive;
    req  = reqv;
    for (int k = 0; k < dly; k++) begin
      tpu_output_valid = ($urandom_range(0, 3) == 0);
      if (tpu_output_valid) push_exp(K_RES, oh(w), cyc);
      if (rnd && $urandom_range(0, 3) == 0) begin
        reqv = reqv | R'($urandom_range(0, (1 << R) - 1));
        req  = reqv;
      end
      step();
    end
    tpu_done = 1'b1;
    tpu_output_valid = 1'($urandom_range(0, 1));
    if (tpu_output_valid) push_exp(K_RES, oh(w), cyc);
    push_exp(K_DONE, oh(w), cyc + 1);
    step();
    tpu_done = 1'b0;
    tpu_output_valid = 1'($urandom_range(0, 1));
    if (tpu_output_valid) push_exp(K_RES, oh(w), cyc);
    reqv[w] = keep;
    req = reqv;
    mptr = (w + 1) % R;
    step();
    tpu_output_valid = 1'b0;
  endtask

  // In IDLE: optional noise and gaps until at least one request is raised.
  task automatic idle_fill();
    int guard = 0;
    while (reqv == '0 && guard < 20) begin
      guard++;
      case ($urandom_range(0, 2))
        0: begin
          tpu_done = 1'b1;
          tpu_output_valid = 1'b1;
          step();
          tpu_done = 1'b0;
          tpu_output_valid = 1'b0;
          chk("noise_busy", {63'd0, busy}, 64'd0);
          chk("noise_start", {63'd0, tpu_start}, 64'd0);
        end
        1: step();
        default: begin
          reqv = R'($urandom_range(1, (1 << R) - 1));
          req  = reqv;
        end
      endcase
    end
    if (reqv == '0) begin
      reqv = 1;
      req  = reqv;
    end
  endtask

  task automatic drain();
    int w;
    while (reqv != '0) begin
      arbitrate(w);
      run_body(w, $urandom_range(0, 4), 1'b0, '0, 1'b0);
    end
  endtask

  initial begin
    int w;
    rst = 1'b1;
    req = '0;
    reqv = '0;
    mptr = 0;
    tpu_done = 1'b0;
    tpu_output_valid = 1'b0;
    act_in = rand_vec();
    weight_in = rand_vec();
    repeat (3) step();
    chk("rst_grant", grant, 0);
    chk("rst_busy", {63'd0, busy}, 0);
    chk("rst_job_done", job_done, 0);
    chk("rst_job_err", job_err, 0);
    chk("rst_tpu_srst", {63'd0, tpu_srst}, 0);
    chk("rst_tpu_start", {63'd0, tpu_start}, 0);
    chk("rst_act_data", act_data, 0);
    rst = 1'b0;

    // Full contention: all requesters held; order 0,1,2,3,0, then drain.
    reqv = '1;
    for (int j = 0; j < 5; j++) begin
      arbitrate(w);
      run_body(w, $urandom_range(0, 5), 1'b1, '0, 1'b0);
    end
    drain();

    // Single requester.
    reqv = 4'b0010;
    arbitrate(w);
    run_body(w, 6, 1'b0, '0, 1'b0);

    // Late arrival of req1 during requester 2's job, with and without req3.
    reqv = 4'b0100;
    arbitrate(w);
    run_body(w, 4, 1'b0, 4'b0010, 1'b0);
    drain();
    reqv = 4'b0100;
    arbitrate(w);
    run_body(w, 3, 1'b0, 4'b1010, 1'b0);
    drain();

    // Idle noise: tpu_done/tpu_output_valid while nothing is requested.
    for (int j = 0; j < 3; j++) begin
      tpu_done = 1'b1;
      tpu_output_valid = 1'b1;
      step();
      tpu_done = 1'b0;
      tpu_output_valid = 1'b0;
      chk("idle_busy", {63'd0, busy}, 0);
      chk("idle_job_done", job_done, 0);
      chk("idle_res_valid", res_valid, 0);
    end

    // Randomized traffic.
    for (int j = 0; j < 40; j++) begin
      idle_fill();
      arbitrate(w);
      run_body(w, $urandom_range(0, 8), ($urandom_range(0, 3) == 0), '0, 1'b1);
    end
    drain();

    // Reset mid-RUN while requester 2 owns the TPU (pointer sits at 2).
    reqv = 4'b0010;
    arbitrate(w);
    run_body(w, 2, 1'b0, '0, 1'b0);
    reqv = 4'b0100;
    arbitrate(w);
    step();
    rst = 1'b1;
    reqv = '0;
    req = '0;
    step();
    chk("midrst_grant", grant, 0);
    chk("midrst_busy", {63'd0, busy}, 0);
    chk("midrst_job_done", job_done, 0);
    rst = 1'b0;
    mptr = 0;
    reqv = '1;
    arbitrate(w);
    run_body(w, 2, 1'b0, '0, 1'b0);
    drain();

`ifdef TPU_ARB_WATCHDOG_EN
    // Hung job: abort pulse 16 cycles after RUN entry, then IDLE.
    reqv = 4'b0001;
    arbitrate(w);
    push_exp(K_ERR, oh(w), cyc + TIMEOUT);
    for (int k = 0; k < TIMEOUT; k++) step();
    reqv[w] = 1'b0;
    req = reqv;
    mptr = (w + 1) % R;
    chk("wd_busy_after_abort", {63'd0, busy}, 0);
    // tpu_done exactly at the expiry cycle: normal completion only.
    reqv = 4'b0100;
    arbitrate(w);
    run_body(w, TIMEOUT - 1, 1'b0, '0, 1'b0);
`endif

    repeat (4) step();
    chk("expect_queue_empty", 64'(expq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tpu_job_arbiter.md
Name: tpu_job_arbiter

Overview:
- Round-robin arbiter that shares one tpu_top instance between R independent requesters (e.g. DMA engines or host queues).
- Grants the TPU to one requester for exactly one complete job and pulses tpu_start.
- While granted, muxes that requester's act/weight streams into the array.
- Routes tpu_done / tpu_output_valid back to the owner as per-requester pulses.
- Sits directly above tpu_top; tpu_controller stays unchanged.

Parameters:
- N, 8, array dimension; act/weight vectors are N*8 bits.
- R, 4, number of requesters (2..16).
- TIMEOUT, 4096, watchdog limit in cycles (used only when the watchdog is compiled in).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req  in  R  per-requester job request, level; held until the matching job_done or job_err.
- act_in  in  R*N*8  per-requester activation vectors; slice i = bits [i*N*8 +: N*8].
- weight_in  in  R*N*8  per-requester weight vectors, same slicing.
- grant  out  R  one-hot owner indication; all zero when idle.
- job_done  out  R  one-cycle completion pulse to the owner.
- res_valid  out  R  tpu_output_valid qualified by grant.
- busy  out  1  high in every state except IDLE.
- tpu_start  out  1  start pulse to tpu_top.
- tpu_done  in  1  from tpu_top.
- tpu_output_valid  in  1  from tpu_top.
- act_data  out  N*8  muxed activations to tpu_top.
- weight_data  out  N*8  muxed weights to tpu_top.
- job_err  out  R  watchdog abort pulse; tied 0 without the feature.
- tpu_srst  out  1  one-cycle TPU reset request; tied 0 without the feature.

Behaviour:
- Clocking and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, grant=0, job_done=0, job_err=0, tpu_start=0, tpu_srst=0, busy=0, rr_ptr=0, owner=0.
  - A rst asserted mid-job returns to IDLE next cycle with no job_done pulse.
  - Requesters must re-request after reset.
- State machine:
  - IDLE: if req!=0, choose the winner, register owner and grant, go to START. Otherwise stay.
  - START: tpu_start=1 for exactly this cycle, go to RUN. tpu_done is ignored in START.
  - RUN: wait for tpu_done=1, then go to RELEASE.
  - RELEASE: job_done[owner]=1 for one cycle; grant cleared at the end of the cycle; rr_ptr=(owner+1) mod R; go to IDLE.
- Latency:
  - req seen in IDLE at cycle t → grant and tpu_start visible at t+1 (registered).
  - tpu_done at cycle u in RUN → job_done at u+1.
  - Minimum IDLE gap between jobs is 1 cycle, so back-to-back jobs from different requesters are at least 4 cycles apart plus TPU time.
- Arbitration:
  - Search starts at rr_ptr and wraps modulo R; the first set req bit wins.
  - req is sampled only in IDLE. Dropping req after grant does not abort the job.
  - A new req arriving during a job waits. Its priority follows the rotation only, not arrival order.
- Data mux:
  - act_data/weight_data = slice[owner] while grant!=0; otherwise all zeros.
  - Combinational from owner, so no extra latency.
- res_valid[i] = tpu_output_valid & grant[i]. The result bus goes straight from tpu_top to all requesters.
- Simultaneous events:
  - tpu_done and tpu_output_valid in the same RUN cycle: res_valid pulses and the state moves to RELEASE; grant stays high through RELEASE.
  - tpu_done while IDLE is ignored.

Optional Feature:
- Macro: TPU_ARB_WATCHDOG_EN.
- With the macro:
  - A counter clears on START and increments each RUN cycle.
  - On reaching TIMEOUT-1 without tpu_done, the next cycle pulses job_err[owner] and tpu_srst for one cycle.
  - No job_done pulse is issued; rr_ptr advances as in RELEASE; state returns to IDLE.
  - tpu_done arriving in the same cycle as expiry takes priority (normal completion).
- Without the macro: no counter; job_err=0 and tpu_srst=0 constant; RUN waits indefinitely.

Decomposition:
- Shared package tpu_pkg holds:
  - the state encoding (IDLE=0, START=1, RUN=2, RELEASE=3) as a typedef;
  - the vector width constant ACT_W = 8;
  - the slice-index helper.
- One natural sub-module: rr_pick, a combinational rotating priority encoder (inputs: req, ptr; outputs: one-hot winner and index, valid).

Test Plan:
- Single requester: req=4'b0010 → grant=0010 and tpu_start at t+1; act_data equals act_in slice 1; tpu_done at cycle 20 → job_done=0010 at 21; grant=0 at 22.
- Full contention: req=4'b1111 held and each done returned → grant order 0,1,2,3,0; rr_ptr wraps from 3 to 0.
- Late arrival: req1 rises mid-job of requester 2 → after release, order is 3 before 1 only if req3 is set; otherwise 1.
- Reset mid-RUN: rst for 1 cycle while owner=2 → next cycle grant=0, busy=0, no job_done, rr_ptr=0.
- Idle noise: tpu_done and tpu_output_valid pulsed while IDLE → all outputs remain 0.
- Watchdog (TPU_ARB_WATCHDOG_EN, TIMEOUT=16): tpu_done never asserted → job_err[owner] and tpu_srst pulse exactly 16 cycles after RUN entry, then IDLE. Repeat with tpu_done arriving at the expiry cycle → job_done only.
